// File: rtl/tlb_dual.sv
// Dual-port fully associative MIPS32 joint TLB with CP0 op port and Random counter.
// Optional: define TLB_MCHECK_EN to add the sticky multiple-match detector output mcheck.
module tlb_dual #(
  parameter int ENTRIES = 32,
  parameter int IDXW    = 6,
  parameter int ASIDW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ASIDW-1:0]  asid,
  input  logic              i_req,
  input  logic [31:0]       i_vaddr,
  output logic [31:0]       i_paddr,
  output logic [2:0]        i_cache,
  output logic              i_miss,
  output logic              i_invalid,
  input  logic              d_req,
  input  logic [31:0]       d_vaddr,
  input  logic              d_store,
  output logic [31:0]       d_paddr,
  output logic [2:0]        d_cache,
  output logic              d_miss,
  output logic              d_invalid,
  output logic              d_modify,
  input  logic              op_valid,
  input  logic [1:0]        op,
  input  logic [IDXW-1:0]   index_in,
  input  logic [11:0]       mask_in,
  input  logic [31:0]       entryhi_in,
  input  logic [31:0]       entrylo0_in,
  input  logic [31:0]       entrylo1_in,
  input  logic [IDXW-1:0]   wired,
  input  logic              wired_wen,
  output logic              op_done,
  output logic              probe_fail,
  output logic [IDXW-1:0]   probe_idx,
  output logic [11:0]       rd_mask,
  output logic [31:0]       rd_entryhi,
  output logic [31:0]       rd_entrylo0,
  output logic [31:0]       rd_entrylo1,
  output logic [IDXW-1:0]   random
`ifdef TLB_MCHECK_EN
  ,output logic             mcheck
`endif
);

  localparam int EW = $clog2(ENTRIES);
  localparam logic [IDXW-1:0] TOP = IDXW'(ENTRIES-1);
  localparam logic [1:0] OP_R = 2'b00, OP_WI = 2'b01, OP_WR = 2'b10, OP_P = 2'b11;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } page_t;

  typedef struct packed {
    logic             present;
    logic [11:0]      mask;
    logic [18:0]      vpn2;
    logic [ASIDW-1:0] asid;
    logic             g;
    page_t            lo0;
    page_t            lo1;
  } ent_t;

  typedef ent_t [ENTRIES-1:0] ent_arr_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  cache;
    logic        miss;
    logic        invalid;
    logic        modify;
  } res_t;

  typedef struct packed {
    res_t r;
    logic multi;
  } lk_t;

  function automatic logic ent_match(ent_t e, logic [18:0] vpn2, logic [ASIDW-1:0] a);
    logic [18:0] m;
    m = {7'b0, e.mask};
    return e.present && ((vpn2 & ~m) == (e.vpn2 & ~m)) && (e.g || (e.asid == a));
  endfunction

  // Matches are OR-combined; multi flags more than one hit for the checker.
  function automatic lk_t lookup(ent_arr_t ents, logic [31:0] va, logic [ASIDW-1:0] a, logic st);
    lk_t         lk;
    page_t       pg, sp;
    logic [31:0] pa, pe;
    logic [4:0]  bi;
    int          n;
    lk = '0; pg = '0; pa = '0; n = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent_match(ents[i], va[31:13], a)) begin
        bi = 5'd12 + 5'($countones(ents[i].mask));
        sp = va[bi] ? ents[i].lo1 : ents[i].lo0;
        pe = {sp.pfn[19:12], 12'h0, va[11:0]};
        for (int j = 0; j < 12; j++)
          pe[12+j] = ents[i].mask[j] ? va[12+j] : sp.pfn[j];
        pa = pa | pe;
        pg = pg | sp;
        n  = n + 1;
      end
    end
    lk.r.miss    = (n == 0);
    lk.r.paddr   = (n != 0) ? pa : 32'h0;
    lk.r.cache   = (n != 0) ? pg.c : 3'h0;
    lk.r.invalid = (n != 0) && !pg.v;
    lk.r.modify  = (n != 0) && pg.v && st && !pg.d;
    lk.multi     = (n > 1);
    return lk;
  endfunction

  ent_arr_t        ent_q, ent_d;
  res_t            i_res_q, i_res_d, d_res_q, d_res_d;
  lk_t             i_lk, d_lk;
  ent_t            nw, rsel;
  logic            idx_ok, we;
  logic [EW-1:0]   wr_idx;
  logic            op_done_q, op_done_d;
  logic            probe_fail_q, probe_fail_d;
  logic [IDXW-1:0] probe_idx_q, probe_idx_d;
  logic [11:0]     rd_mask_q, rd_mask_d;
  logic [31:0]     rd_hi_q, rd_hi_d, rd_lo0_q, rd_lo0_d, rd_lo1_q, rd_lo1_d;
  logic [IDXW-1:0] random_q, random_d;

  always_comb begin
    nw         = '0;
    nw.present = 1'b1;
    nw.mask    = mask_in;
    nw.vpn2    = entryhi_in[31:13];
    nw.asid    = entryhi_in[ASIDW-1:0];
    nw.g       = entrylo0_in[0] & entrylo1_in[0];
    nw.lo0     = entrylo0_in[25:1];
    nw.lo1     = entrylo1_in[25:1];
    idx_ok     = {1'b0, index_in} < (IDXW+1)'(ENTRIES);
    we         = op_valid && (((op == OP_WI) && idx_ok) || (op == OP_WR));
    wr_idx     = (op == OP_WR) ? random_q[EW-1:0] : index_in[EW-1:0];
    ent_d      = ent_q;
    if (we) ent_d[wr_idx] = nw;
  end

  // Lookups see ent_q, so a write in the same cycle is not yet visible.
  always_comb begin
    i_lk    = lookup(ent_q, i_vaddr, asid, 1'b0);
    d_lk    = lookup(ent_q, d_vaddr, asid, d_store);
    i_res_d = i_req ? i_lk.r : i_res_q;
    d_res_d = d_req ? d_lk.r : d_res_q;
  end

  always_comb begin
    op_done_d    = op_valid;
    probe_fail_d = probe_fail_q;
    probe_idx_d  = probe_idx_q;
    rd_mask_d    = rd_mask_q;
    rd_hi_d      = rd_hi_q;
    rd_lo0_d     = rd_lo0_q;
    rd_lo1_d     = rd_lo1_q;
    rsel         = idx_ok ? ent_q[index_in[EW-1:0]] : '0;
    if (op_valid && (op == OP_P)) begin
      probe_fail_d = 1'b1;
      probe_idx_d  = '0;
      for (int k = ENTRIES-1; k >= 0; k--) begin
        if (ent_match(ent_q[k], entryhi_in[31:13], entryhi_in[ASIDW-1:0])) begin
          probe_fail_d = 1'b0;
          probe_idx_d  = IDXW'(k);
        end
      end
    end
    if (op_valid && (op == OP_R)) begin
      rd_mask_d              = rsel.mask;
      rd_hi_d                = '0;
      rd_hi_d[31:13]         = rsel.vpn2;
      rd_hi_d[ASIDW-1:0]     = rsel.asid;
      rd_lo0_d               = {6'b0, rsel.lo0, rsel.g};
      rd_lo1_d               = {6'b0, rsel.lo1, rsel.g};
    end
    if (wired_wen || ({1'b0, wired} >= (IDXW+1)'(ENTRIES-1)) || (random_q == wired))
      random_d = TOP;
    else
      random_d = random_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q        <= '0;
      i_res_q      <= '0;
      d_res_q      <= '0;
      op_done_q    <= 1'b0;
      probe_fail_q <= 1'b0;
      probe_idx_q  <= '0;
      rd_mask_q    <= '0;
      rd_hi_q      <= '0;
      rd_lo0_q     <= '0;
      rd_lo1_q     <= '0;
      random_q     <= TOP;
    end else begin
      ent_q        <= ent_d;
      i_res_q      <= i_res_d;
      d_res_q      <= d_res_d;
      op_done_q    <= op_done_d;
      probe_fail_q <= probe_fail_d;
      probe_idx_q  <= probe_idx_d;
      rd_mask_q    <= rd_mask_d;
      rd_hi_q      <= rd_hi_d;
      rd_lo0_q     <= rd_lo0_d;
      rd_lo1_q     <= rd_lo1_d;
      random_q     <= random_d;
    end
  end

  assign i_paddr     = i_res_q.paddr;
  assign i_cache     = i_res_q.cache;
  assign i_miss      = i_res_q.miss;
  assign i_invalid   = i_res_q.invalid;
  assign d_paddr     = d_res_q.paddr;
  assign d_cache     = d_res_q.cache;
  assign d_miss      = d_res_q.miss;
  assign d_invalid   = d_res_q.invalid;
  assign d_modify    = d_res_q.modify;
  assign op_done     = op_done_q;
  assign probe_fail  = probe_fail_q;
  assign probe_idx   = probe_idx_q;
  assign rd_mask     = rd_mask_q;
  assign rd_entryhi  = rd_hi_q;
  assign rd_entrylo0 = rd_lo0_q;
  assign rd_entrylo1 = rd_lo1_q;
  assign random      = random_q;

  logic unused_ok;

`ifdef TLB_MCHECK_EN
  function automatic logic pair_match(ent_t a, ent_t b);
    logic [18:0] m;
    m = {7'b0, a.mask | b.mask};
    return a.present && b.present && (((a.vpn2 ^ b.vpn2) & ~m) == '0) &&
           (a.g || b.g || (a.asid == b.asid));
  endfunction

  logic mcheck_q, mcheck_d, wr_conflict;

  // The slot being overwritten is excluded: it will no longer exist after the write.
  always_comb begin
    wr_conflict = 1'b0;
    for (int k = 0; k < ENTRIES; k++)
      if ((EW'(k) != wr_idx) && pair_match(ent_q[k], nw)) wr_conflict = 1'b1;
    mcheck_d = mcheck_q | (we & wr_conflict) | (i_req & i_lk.multi) | (d_req & d_lk.multi);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mcheck_q <= 1'b0;
    else     mcheck_q <= mcheck_d;
  end

  assign mcheck    = mcheck_q;
  assign unused_ok = ^{entryhi_in[12:ASIDW], entrylo0_in[31:26], entrylo1_in[31:26], i_res_q.modify};
`else
  assign unused_ok = ^{entryhi_in[12:ASIDW], entrylo0_in[31:26], entrylo1_in[31:26], i_res_q.modify,
                       i_lk.multi, d_lk.multi};
`endif

endmodule

// File: tb/tb_tlb_dual.sv
// Directed bench for tlb_dual: table of lookup vectors plus hand sequences for CP0 ops,
// Random counter, write/lookup ordering and reset mid-operation.
module tb_tlb_dual;

  logic        clk, rst;
  logic [7:0]  asid;
  logic        i_req, d_req, d_store;
  logic [31:0] i_vaddr, d_vaddr, i_paddr, d_paddr;
  logic [2:0]  i_cache, d_cache;
  logic        i_miss, i_invalid, d_miss, d_invalid, d_modify;
  logic        op_valid;
  logic [1:0]  op;
  logic [5:0]  index_in, wired, probe_idx, random;
  logic [11:0] mask_in, rd_mask;
  logic [31:0] entryhi_in, entrylo0_in, entrylo1_in;
  logic [31:0] rd_entryhi, rd_entrylo0, rd_entrylo1;
  logic        wired_wen, op_done, probe_fail;
`ifdef TLB_MCHECK_EN
  logic        mcheck;
`endif

  tlb_dual dut (
    .clk(clk), .rst(rst), .asid(asid),
    .i_req(i_req), .i_vaddr(i_vaddr), .i_paddr(i_paddr), .i_cache(i_cache),
    .i_miss(i_miss), .i_invalid(i_invalid),
    .d_req(d_req), .d_vaddr(d_vaddr), .d_store(d_store), .d_paddr(d_paddr),
    .d_cache(d_cache), .d_miss(d_miss), .d_invalid(d_invalid), .d_modify(d_modify),
    .op_valid(op_valid), .op(op), .index_in(index_in), .mask_in(mask_in),
    .entryhi_in(entryhi_in), .entrylo0_in(entrylo0_in), .entrylo1_in(entrylo1_in),
    .wired(wired), .wired_wen(wired_wen), .op_done(op_done),
    .probe_fail(probe_fail), .probe_idx(probe_idx),
    .rd_mask(rd_mask), .rd_entryhi(rd_entryhi), .rd_entrylo0(rd_entrylo0),
    .rd_entrylo1(rd_entrylo1), .random(random)
`ifdef TLB_MCHECK_EN
    ,.mcheck(mcheck)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic        iport;
    logic [31:0] va;
    logic        st;
    logic [7:0]  as;
    logic [31:0] pa;
    logic [2:0]  c;
    logic        miss, inv, mod;
  } vec_t;

  vec_t vt[11];
  logic [5:0] exp_r;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cp0(input logic [1:0] o, input logic [5:0] idx, input logic [11:0] m,
                     input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
    op_valid = 1'b1; op = o; index_in = idx; mask_in = m;
    entryhi_in = hi; entrylo0_in = lo0; entrylo1_in = lo1;
    step();
    op_valid = 1'b0;
    chk("op_done", op_done, 1);
  endtask

  task automatic dlook(input logic [31:0] va, input logic st, input logic [7:0] a);
    d_req = 1'b1; d_vaddr = va; d_store = st; asid = a;
    step();
    d_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{"d_st_even",   1'b0, 32'h00400abc, 1'b1, 8'd5, 32'h00012abc, 3'd3, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{"d_st_odd",    1'b0, 32'h00401abc, 1'b1, 8'd5, 32'h00034abc, 3'd3, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{"d_ld_even",   1'b0, 32'h00400abc, 1'b0, 8'd5, 32'h00012abc, 3'd3, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{"d_asid_miss", 1'b0, 32'h00400abc, 1'b1, 8'd6, 32'h00000000, 3'd0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{"i_m3_odd",    1'b1, 32'h00406123, 1'b0, 8'd9, 32'h00abe123, 3'd2, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{"i_m3_inv",    1'b1, 32'h00402123, 1'b0, 8'd9, 32'h00056123, 3'd2, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{"d_16m_odd",   1'b0, 32'h43800345, 1'b1, 8'd6, 32'h7f800345, 3'd5, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{"d_16m_even",  1'b0, 32'h42123456, 1'b1, 8'd6, 32'h11123456, 3'd5, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{"i_even",      1'b1, 32'h00400abc, 1'b0, 8'd5, 32'h00012abc, 3'd3, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{"d_m3_vpn2",   1'b0, 32'h00404000, 1'b0, 8'd9, 32'h00abc000, 3'd2, 1'b0, 1'b0, 1'b0};
    vt[10] = '{"d_16m_miss",  1'b0, 32'h44000000, 1'b0, 8'd6, 32'h00000000, 3'd0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; asid = '0; i_req = 0; d_req = 0; d_store = 0; i_vaddr = '0; d_vaddr = '0;
    op_valid = 0; op = '0; index_in = '0; mask_in = '0; entryhi_in = '0;
    entrylo0_in = '0; entrylo1_in = '0; wired = '0; wired_wen = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_random", random, 6'd31);
    chk("rst_outs", {d_paddr, d_miss, i_miss, op_done, probe_fail, rd_entryhi[15:0]}, 0);
    rst = 1'b0;

    dlook(32'h00401000, 1'b0, 8'd0);
    chk("empty_miss", {d_paddr, d_cache, d_miss, d_invalid, d_modify}, {32'h0, 3'd0, 3'b100});

    cp0(2'b01, 6'd3,  12'h000, 32'h00400005, 32'h0000049a, 32'h00000d1e);
    cp0(2'b01, 6'd7,  12'h003, 32'h00400009, 32'h00001550, 32'h0002af16);
    cp0(2'b01, 6'd10, 12'hfff, 32'h42000000, 32'h0044002b, 32'h01fc002f);
    step();
    chk("op_done_pulse", op_done, 0);

    for (int k = 0; k < 11; k++) begin
      asid = vt[k].as;
      if (vt[k].iport) begin i_req = 1'b1; i_vaddr = vt[k].va; end
      else begin d_req = 1'b1; d_vaddr = vt[k].va; d_store = vt[k].st; end
      step();
      i_req = 1'b0; d_req = 1'b0;
      if (vt[k].iport)
        chk(vt[k].nm, {i_paddr, i_cache, i_miss, i_invalid, 1'b0},
            {vt[k].pa, vt[k].c, vt[k].miss, vt[k].inv, vt[k].mod});
      else
        chk(vt[k].nm, {d_paddr, d_cache, d_miss, d_invalid, d_modify},
            {vt[k].pa, vt[k].c, vt[k].miss, vt[k].inv, vt[k].mod});
    end

    // global rewrite of entry 3 makes a foreign ASID hit
    cp0(2'b01, 6'd3, 12'h000, 32'h00400005, 32'h0000049b, 32'h00000d1f);
    dlook(32'h00400abc, 1'b0, 8'd6);
    chk("global_hit", {d_paddr, d_cache, d_miss}, {32'h00012abc, 3'd3, 1'b0});

    // write and lookup in the same cycle: old contents, then new
    op_valid = 1'b1; op = 2'b01; index_in = 6'd12; mask_in = '0;
    entryhi_in = 32'h60000000; entrylo0_in = 32'h00002647; entrylo1_in = 32'h1;
    d_req = 1'b1; d_vaddr = 32'h60000010; d_store = 1'b0; asid = 8'd6;
    step();
    op_valid = 1'b0; d_req = 1'b0;
    chk("same_cyc_old", {d_miss, op_done}, 2'b11);
    dlook(32'h60000010, 1'b0, 8'd6);
    chk("next_cyc_new", {d_paddr, d_miss}, {32'h00099010, 1'b0});
    repeat (3) step();
    chk("hold_idle", {d_paddr, d_miss}, {32'h00099010, 1'b0});

    cp0(2'b11, 6'd0, 12'h0, 32'h00400005, 32'h0, 32'h0);
    chk("probe_3", {probe_fail, probe_idx}, {1'b0, 6'd3});
    cp0(2'b11, 6'd0, 12'h0, 32'h00402009, 32'h0, 32'h0);
    chk("probe_7", {probe_fail, probe_idx}, {1'b0, 6'd7});
    cp0(2'b11, 6'd0, 12'h0, 32'h00400009, 32'h0, 32'h0);
    chk("probe_lowest", {probe_fail, probe_idx}, {1'b0, 6'd3});
    cp0(2'b11, 6'd0, 12'h0, 32'h12344005, 32'h0, 32'h0);
    chk("probe_fail", {probe_fail, probe_idx}, {1'b1, 6'd0});

    cp0(2'b00, 6'd7, 12'h0, 32'h0, 32'h0, 32'h0);
    chk("tlbr7_hi", {rd_mask, rd_entryhi}, {12'h003, 32'h00400009});
    chk("tlbr7_lo", {rd_entrylo0, rd_entrylo1}, {32'h00001550, 32'h0002af16});
    cp0(2'b00, 6'd3, 12'h0, 32'h0, 32'h0, 32'h0);
    chk("tlbr3_lo", {rd_entrylo0, rd_entrylo1}, {32'h0000049b, 32'h00000d1f});

    // index 40 is out of range: write dropped, read returns zeros
    cp0(2'b01, 6'd40, 12'h0, 32'h12344005, 32'h3, 32'h3);
    cp0(2'b00, 6'd40, 12'h0, 32'h0, 32'h0, 32'h0);
    chk("tlbr_oor", {rd_mask, rd_entryhi}, 0);
    cp0(2'b00, 6'd8, 12'h0, 32'h0, 32'h0, 32'h0);
    chk("tlbr_alias8", {rd_entryhi, rd_entrylo0}, 0);
    cp0(2'b11, 6'd0, 12'h0, 32'h12344005, 32'h0, 32'h0);
    chk("probe_oor", probe_fail, 1);

    wired = 6'd4; wired_wen = 1'b1;
    step();
    wired_wen = 1'b0;
    exp_r = 6'd31;
    chk("rand_wwen", random, exp_r);
    for (int k = 0; k < 40; k++) begin
      step();
      exp_r = (exp_r == 6'd4) ? 6'd31 : exp_r - 6'd1;
      chk("rand_seq", random, exp_r);
    end
    for (int k = 0; k < 40 && exp_r != 6'd20; k++) begin
      step();
      exp_r = (exp_r == 6'd4) ? 6'd31 : exp_r - 6'd1;
    end
    op_valid = 1'b1; op = 2'b10; index_in = 6'd0; mask_in = '0;
    entryhi_in = 32'h7fff2033; entrylo0_in = 32'h00000f87; entrylo1_in = 32'h00000f86;
    step();
    op_valid = 1'b0;
    chk("tlbwr_done", {op_done, random}, {1'b1, 6'd19});
    cp0(2'b00, 6'd19, 12'h0, 32'h0, 32'h0, 32'h0);
    chk("tlbwr_not19", rd_entryhi, 0);
    cp0(2'b00, 6'd20, 12'h0, 32'h0, 32'h0, 32'h0);
    chk("tlbwr_hi20", {rd_mask, rd_entryhi}, {12'h0, 32'h7fff2033});
    chk("tlbwr_lo20", {rd_entrylo0, rd_entrylo1}, {32'h00000f86, 32'h00000f86});

    wired = 6'd31; wired_wen = 1'b1;
    step();
    wired_wen = 1'b0;
    repeat (3) step();
    chk("rand_hold", random, 6'd31);
    wired = 6'd0;

    // reset lands while an op and a lookup are in flight
    op_valid = 1'b1; op = 2'b11; entryhi_in = 32'h00400005;
    d_req = 1'b1; d_vaddr = 32'h00400abc; d_store = 1'b0; asid = 8'd5;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0; d_req = 1'b0;
    chk("rst_mid_outs", {op_done, probe_fail, probe_idx, d_paddr, d_miss}, 0);
    chk("rst_mid_rd", {rd_entryhi, rd_entrylo0}, 0);
    chk("rst_mid_rand", random, 6'd31);
    rst = 1'b0;
    dlook(32'h00400abc, 1'b0, 8'd5);
    chk("rst_cleared", {d_paddr, d_miss}, {32'h0, 1'b1});
    cp0(2'b11, 6'd0, 12'h0, 32'h00400005, 32'h0, 32'h0);
    chk("rst_probe", {probe_fail, probe_idx}, {1'b1, 6'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb_dual.md
Name: tlb_dual

Overview:
- Second-generation joint TLB for the MIPS32 MMU.
- Fully associative, ENTRIES entries, variable page size (4K–16M through PageMask), two registered lookup ports (fetch and data).
- CP0 operation port for TLBR/TLBWI/TLBWR/TLBP, with an internal Random counter bounded below by Wired.
- Sits between the CP0 register file and the IF/MEM address paths; kseg0/kseg1 bypass is handled outside.

Parameters:
- ENTRIES, 32, number of TLB entries; power of two, 4..64.
- IDXW, 6, index width; must satisfy 2**IDXW >= ENTRIES.
- ASIDW, 8, ASID width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- asid  in  ASIDW  current ASID (EntryHi[ASIDW-1:0])
- i_req  in  1  fetch lookup strobe
- i_vaddr  in  32  fetch virtual address
- i_paddr, i_cache, i_miss, i_invalid  out  32,3,1,1  fetch result, registered
- d_req  in  1  data lookup strobe
- d_vaddr  in  32  data virtual address
- d_store  in  1  lookup is a store
- d_paddr, d_cache, d_miss, d_invalid, d_modify  out  32,3,1,1,1  data result, registered
- op_valid  in  1  CP0 op strobe
- op  in  2  00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP
- index_in  in  IDXW  CP0 Index
- mask_in  in  12  PageMask[24:13]
- entryhi_in, entrylo0_in, entrylo1_in  in  32  CP0 sources
- wired  in  IDXW  CP0 Wired value
- wired_wen  in  1  Wired written this cycle
- op_done  out  1  pulse, result of op valid
- probe_fail, probe_idx  out  1,IDXW  TLBP result
- rd_mask, rd_entryhi, rd_entrylo0, rd_entrylo1  out  12,32,32,32  TLBR result
- random  out  IDXW  CP0 Random

Behaviour:
- Entry storage:
  - Each entry holds: present bit, mask, VPN2 (entryhi[31:13]), ASID, G = lo0[0] & lo1[0].
  - Each entry also holds two pages: {PFN 20b, C, D, V}, taken from entrylo[25:1].
  - rst clears every present bit. A non-present entry never matches.
- Match condition: present && (vaddr[31:13] & ~mask) == (VPN2 & ~mask) && (G || ASID == asid).
- Odd/even select:
  - Select bit is vaddr[12+p], where p = popcount(mask). Legal masks: 000,003,00F,03F,0FF,3FF,FFF.
  - Any other mask value gives undefined translation; the write is still performed.
- Address formation:
  - paddr[11:0] = vaddr[11:0].
  - For j = 0..11: paddr[12+j] = mask[j] ? vaddr[12+j] : PFN[j].
  - paddr[31:24] = PFN[19:12].
- Lookup latency: 1 cycle.
  - Result registered on the edge where the port's req=1.
  - Outputs hold their value while req=0.
  - Reset value of all lookup outputs: 0.
- Fault flags:
  - miss = no match.
  - invalid = match && !V.
  - modify = match && V && d_store && !D.
  - On miss, paddr and cache are 0.
- Multiple matches: OR-combined results, undefined by spec (see optional feature).
- CP0 ops: accepted whenever op_valid=1; no backpressure. op_done pulses exactly 1 cycle later.
  - TLBWI: writes the entry at index_in on the accepting edge.
  - TLBWR: writes the entry at the current random value on the accepting edge.
  - TLBR: rd_* are registered from entry index_in.
    - rd_entryhi[7:0] is the stored ASID, and rd_entrylo*[0] = G.
    - Unused fields read 0.
  - TLBP: compares entryhi_in (VPN2, ASID) against all entries using the match rule.
    - probe_fail = no match.
    - probe_idx = lowest matching index, or 0 on fail.
- Write/lookup ordering:
  - A lookup in the same cycle as a write sees the old contents.
  - Lookups from the next cycle onward see the new contents.
- Out-of-range index: index_in >= ENTRIES on TLBWI/TLBR is ignored. op_done still pulses, and rd_* read 0.
- Random counter:
  - Resets to ENTRIES-1 and decrements every cycle.
  - When random == wired, the next value is ENTRIES-1.
  - wired_wen forces the next value to ENTRIES-1.
  - If wired >= ENTRIES-1, random holds at ENTRIES-1.
  - A TLBWR in the same cycle uses the pre-update value.
- Reset mid-operation: a pending op_done, probe or read result is discarded. All outputs return to 0, except random, which returns to ENTRIES-1.

Optional Feature:
- TLB_MCHECK_EN defined:
  - Adds output mcheck (1 bit, registered, reset 0).
  - mcheck is set when a TLBWI/TLBWR would create two present entries that match each other, comparing VPN2 under the OR of both masks and ASID/G.
  - mcheck is also set when any lookup port sees more than one match.
  - Sticky until rst. An offending write is still performed.
- Undefined: port and logic absent; multiple matches give undefined results.

Test Plan:
- rst, then d_req at 0x00401000 -> next cycle d_miss=1, d_paddr=0; random=ENTRIES-1.
- TLBWI idx 3:
  - Setup: hi=0x00400000 asid 5, lo0 PFN 0x12 V=1 D=0, lo1 PFN 0x34 V=1 D=1, mask 0, asid=5.
  - d_req 0x00400abc store -> d_paddr=0x00012abc, d_modify=1.
  - d_req 0x00401abc store -> d_paddr=0x00034abc, d_modify=0.
- Same entry, asid=6, G=0 -> d_miss=1. Rewrite with both G bits set -> hit.
- Entry with mask 0x003:
  - i_req 0x00406123 -> odd page selected via vaddr[14]=1.
  - i_paddr = {PFN1[19:2], 2'b10, 12'h123}.
- wired=4, run 40 cycles -> random cycles 31..4 then wraps to 31. TLBWR lands at the sampled random; verify with TLBR.
- TLBP:
  - hi matching idx 3 -> op_done next cycle, probe_fail=0, probe_idx=3.
  - Unmatched hi -> probe_fail=1, probe_idx=0.
